// File: rtl/bcd_disp_pkg.sv
// Shared select codes, glyph codes and BCD-to-glyph helper for the 4-digit BCD display scanner.
package bcd_disp_pkg;

  localparam logic [2:0] SEL_A    = 3'b000;
  localparam logic [2:0] SEL_B    = 3'b001;
  localparam logic [2:0] SEL_CIN  = 3'b010;
  localparam logic [2:0] SEL_RSLT = 3'b011;
  localparam logic [2:0] SEL_ERR  = 3'b110;

  // Codes 0..9 are the decimal digits themselves so a valid BCD nibble maps directly.
  localparam logic [4:0] G_0     = 5'd0;
  localparam logic [4:0] G_1     = 5'd1;
  localparam logic [4:0] G_2     = 5'd2;
  localparam logic [4:0] G_3     = 5'd3;
  localparam logic [4:0] G_4     = 5'd4;
  localparam logic [4:0] G_5     = 5'd5;
  localparam logic [4:0] G_6     = 5'd6;
  localparam logic [4:0] G_7     = 5'd7;
  localparam logic [4:0] G_8     = 5'd8;
  localparam logic [4:0] G_9     = 5'd9;
  localparam logic [4:0] G_A     = 5'd10;
  localparam logic [4:0] G_B     = 5'd11;
  localparam logic [4:0] G_C     = 5'd12;
  localparam logic [4:0] G_E     = 5'd13;
  localparam logic [4:0] G_R     = 5'd14;
  localparam logic [4:0] G_DASH  = 5'd15;
  localparam logic [4:0] G_BLANK = 5'd16;

  function automatic logic [4:0] bcd_glyph(input logic [3:0] nib);
    logic [4:0] code;
    if (nib > 4'd9) begin
      code = G_DASH;
    end else begin
      code = {1'b0, nib};
    end
    return code;
  endfunction

endpackage

// File: rtl/bcd_seg7_enc.sv
// Combinational glyph-code to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module bcd_seg7_enc
  import bcd_disp_pkg::*;
(
  input  logic [4:0] glyph,
  output logic [6:0] seg_n
);

  // Glyph lookup; unknown codes fall back to blank.
  always_comb begin
    seg_n = 7'b1111111;
    case (glyph)
      G_0:     seg_n = 7'b1000000;
      G_1:     seg_n = 7'b1111001;
      G_2:     seg_n = 7'b0100100;
      G_3:     seg_n = 7'b0110000;
      G_4:     seg_n = 7'b0011001;
      G_5:     seg_n = 7'b0010010;
      G_6:     seg_n = 7'b0000010;
      G_7:     seg_n = 7'b1111000;
      G_8:     seg_n = 7'b0000000;
      G_9:     seg_n = 7'b0010000;
      G_A:     seg_n = 7'b0001000;
      G_B:     seg_n = 7'b0000011;
      G_C:     seg_n = 7'b1000110;
      G_E:     seg_n = 7'b0000110;
      G_R:     seg_n = 7'b0101111;
      G_DASH:  seg_n = 7'b0111111;
      default: seg_n = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed 4-digit common-anode display driver for the BCD adder: digit scan, content mux,
// error blink and registered pin outputs.
module bcd_display_scan
  import bcd_disp_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] out_mux_sel,
  input  logic [7:0] a_val,
  input  logic [7:0] b_val,
  input  logic       cin_val,
  input  logic [8:0] rslt_val,
  output logic [3:0] an_n,
  output logic [6:0] seg_n
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  logic [PW-1:0] pre_cnt;
  logic [1:0]    dig;
  logic [FW-1:0] frame_cnt;
  logic          blink_on;
  logic [2:0]    sel_q;

  logic       pre_tc;
  logic       frame_tc;
  logic       err_entry;
  logic       dark;
  logic [4:0] glyph;
  logic [6:0] enc_seg;

  assign pre_tc    = (pre_cnt == PW'(SCAN_DIV - 1));
  assign frame_tc  = (frame_cnt == FW'(BLINK_FRAMES - 1));
  assign err_entry = (out_mux_sel == SEL_ERR) && (sel_q != SEL_ERR);
  assign dark      = (sel_q == SEL_ERR) && !blink_on;

  // Select register, prescaler and digit rotation; mode changes never disturb the scan position.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel_q   <= 3'b111;
      pre_cnt <= '0;
      dig     <= 2'd0;
    end else begin
      sel_q <= out_mux_sel;
      if (pre_tc) begin
        pre_cnt <= '0;
        dig     <= dig + 2'd1;
      end else begin
        pre_cnt <= pre_cnt + PW'(1);
      end
    end
  end

  // Frame counter and blink phase; entering ERR restarts a lit half-period.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (err_entry) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (pre_tc && (dig == 2'd3)) begin
      if (frame_tc) begin
        frame_cnt <= '0;
        blink_on  <= !blink_on;
      end else begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end else begin
      frame_cnt <= frame_cnt;
      blink_on  <= blink_on;
    end
  end

  // Content of the currently scanned digit (dig 3 is leftmost).
  always_comb begin
    glyph = G_BLANK;
    case (sel_q)
      SEL_A: begin
        case (dig)
          2'd3:    glyph = G_A;
          2'd1:    glyph = bcd_glyph(a_val[7:4]);
          2'd0:    glyph = bcd_glyph(a_val[3:0]);
          default: glyph = G_BLANK;
        endcase
      end
      SEL_B: begin
        case (dig)
          2'd3:    glyph = G_B;
          2'd1:    glyph = bcd_glyph(b_val[7:4]);
          2'd0:    glyph = bcd_glyph(b_val[3:0]);
          default: glyph = G_BLANK;
        endcase
      end
      SEL_CIN: begin
        case (dig)
          2'd3:    glyph = G_C;
          2'd0:    glyph = cin_val ? G_1 : G_0;
          default: glyph = G_BLANK;
        endcase
      end
      SEL_RSLT: begin
        case (dig)
          2'd2:    glyph = rslt_val[8] ? G_1 : G_BLANK;
          2'd1:    glyph = bcd_glyph(rslt_val[7:4]);
          2'd0:    glyph = bcd_glyph(rslt_val[3:0]);
          default: glyph = G_BLANK;
        endcase
      end
      SEL_ERR: begin
        case (dig)
          2'd3:    glyph = G_E;
          2'd2:    glyph = G_R;
          2'd1:    glyph = G_R;
          default: glyph = G_BLANK;
        endcase
      end
      default: glyph = G_BLANK;
    endcase
  end

  bcd_seg7_enc u_enc (
    .glyph (glyph),
    .seg_n (enc_seg)
  );

  // Registered pin drivers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      an_n  <= 4'b1111;
      seg_n <= 7'b1111111;
    end else if (dark) begin
      an_n  <= 4'b1111;
      seg_n <= 7'b1111111;
    end else begin
      an_n  <= ~(4'b0001 << dig);
      seg_n <= enc_seg;
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Self-checking bench for bcd_display_scan: per-cycle comparison against a character-level display model.
module tb_bcd_display_scan;

  localparam int SD = 4;
  localparam int BF = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] out_mux_sel = 3'b111;
  logic [7:0] a_val = 8'h00;
  logic [7:0] b_val = 8'h00;
  logic       cin_val = 1'b0;
  logic [8:0] rslt_val = 9'h000;
  logic [3:0] an_n;
  logic [6:0] seg_n;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: scan position within a frame, frames into the blink half-period, blink phase, delayed select.
  int         m_pos = 0;
  int         m_frames = 0;
  bit         m_blink = 1'b1;
  logic [2:0] m_sel = 3'b111;
  logic [3:0] exp_an = 4'b1111;
  logic [6:0] exp_seg = 7'b1111111;

  bcd_display_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .out_mux_sel (out_mux_sel),
    .a_val       (a_val),
    .b_val       (b_val),
    .cin_val     (cin_val),
    .rslt_val    (rslt_val),
    .an_n        (an_n),
    .seg_n       (seg_n)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input byte c);
    case (c)
      "0": return 7'b1000000;
      "1": return 7'b1111001;
      "2": return 7'b0100100;
      "3": return 7'b0110000;
      "4": return 7'b0011001;
      "5": return 7'b0010010;
      "6": return 7'b0000010;
      "7": return 7'b1111000;
      "8": return 7'b0000000;
      "9": return 7'b0010000;
      "A": return 7'b0001000;
      "b": return 7'b0000011;
      "C": return 7'b1000110;
      "E": return 7'b0000110;
      "r": return 7'b0101111;
      "-": return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic byte nib(input logic [3:0] n);
    byte c;
    c = (n > 4'd9) ? 8'd45 : 8'(8'd48 + {4'd0, n});
    return c;
  endfunction

  // Character shown at display position d (3 = leftmost) for the given mode and data.
  function automatic byte char_at(input logic [2:0] sel, input int d);
    case (sel)
      3'b000: return (d == 3) ? 8'd65 : (d == 1) ? nib(a_val[7:4]) : (d == 0) ? nib(a_val[3:0]) : 8'd32;
      3'b001: return (d == 3) ? 8'd98 : (d == 1) ? nib(b_val[7:4]) : (d == 0) ? nib(b_val[3:0]) : 8'd32;
      3'b010: return (d == 3) ? 8'd67 : (d == 0) ? (cin_val ? 8'd49 : 8'd48) : 8'd32;
      3'b011: return (d == 2) ? (rslt_val[8] ? 8'd49 : 8'd32) :
                     (d == 1) ? nib(rslt_val[7:4]) : (d == 0) ? nib(rslt_val[3:0]) : 8'd32;
      3'b110: return (d == 3) ? 8'd69 : (d == 2 || d == 1) ? 8'd114 : 8'd32;
      default: return 8'd32;
    endcase
  endfunction

  task automatic model_step();
    int d;
    if (!reset_n) begin
      exp_an = 4'b1111; exp_seg = 7'b1111111;
      m_pos = 0; m_frames = 0; m_blink = 1'b1; m_sel = 3'b111;
    end else begin
      d = m_pos / SD;
      if (m_sel == 3'b110 && !m_blink) begin
        exp_an = 4'b1111; exp_seg = 7'b1111111;
      end else begin
        exp_an = 4'b1111;
        exp_an[d] = 1'b0;
        exp_seg = seg_of(char_at(m_sel, d));
      end
      if (out_mux_sel == 3'b110 && m_sel != 3'b110) begin
        m_frames = 0; m_blink = 1'b1;
      end else if (m_pos == 4 * SD - 1) begin
        m_frames = m_frames + 1;
        if (m_frames == BF) begin
          m_frames = 0; m_blink = !m_blink;
        end
      end
      m_pos = (m_pos + 1) % (4 * SD);
      m_sel = out_mux_sel;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (an_n !== 4'b1111 || seg_n !== 7'b1111111) begin
        n_bad++;
        $display("FAIL reset_hold: an_n=%b seg_n=%b required 1111/1111111", an_n, seg_n);
      end
    end
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      n_cmp++;
      if (an_n !== ~(4'b0001 << (i / 4)) || seg_n !== 7'b1111111) begin
        n_bad++;
        $display("FAIL reset_rotate[%0d]: an_n=%b seg_n=%b required %b/1111111", i, an_n, seg_n, ~(4'b0001 << (i / 4)));
      end
    end
  endtask

  task automatic test_mode_a();
    out_mux_sel = 3'b000;
    a_val = 8'h57;
    for (int i = 0; i < 48; i++) begin
      if (i == 24) a_val = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      tick();
      n_cmp++;
      if (an_n !== exp_an || seg_n !== exp_seg) begin
        n_bad++;
        $display("FAIL mode_a[%0d]: an_n=%b seg_n=%b required %b/%b", i, an_n, seg_n, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_rslt();
    out_mux_sel = 3'b011;
    rslt_val = 9'h198;
    for (int i = 0; i < 40; i++) begin
      if (i == 25) rslt_val = 9'h042;
      tick();
      n_cmp++;
      if (an_n !== exp_an || seg_n !== exp_seg) begin
        n_bad++;
        $display("FAIL rslt[%0d]: an_n=%b seg_n=%b required %b/%b", i, an_n, seg_n, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_b_and_cin();
    out_mux_sel = 3'b001;
    b_val = 8'hA3;
    for (int i = 0; i < 48; i++) begin
      if (i == 20) out_mux_sel = 3'b010;
      if (i == 30) cin_val = 1'b1;
      tick();
      n_cmp++;
      if (an_n !== exp_an || seg_n !== exp_seg) begin
        n_bad++;
        $display("FAIL b_cin[%0d]: an_n=%b seg_n=%b required %b/%b", i, an_n, seg_n, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_err_blink();
    int dark_cycles;
    out_mux_sel = 3'b000;
    tick();
    out_mux_sel = 3'b110;
    dark_cycles = 0;
    for (int i = 0; i < 200; i++) begin
      if (i == 150) out_mux_sel = 3'b000;
      if (i == 155) out_mux_sel = 3'b110;
      tick();
      if (an_n === 4'b1111) dark_cycles++;
      n_cmp++;
      if (an_n !== exp_an || seg_n !== exp_seg) begin
        n_bad++;
        $display("FAIL err_blink[%0d]: an_n=%b seg_n=%b required %b/%b", i, an_n, seg_n, exp_an, exp_seg);
      end
    end
    n_cmp++;
    if (dark_cycles < 32) begin
      n_bad++;
      $display("FAIL err_dark_count: got %0d dark cycles, required at least 32", dark_cycles);
    end
  endtask

  task automatic test_blank_codes();
    for (int i = 0; i < 48; i++) begin
      out_mux_sel = (i < 16) ? 3'b100 : (i < 32) ? 3'b111 : 3'b101;
      a_val = 8'($urandom);
      tick();
      n_cmp++;
      if (an_n !== exp_an || seg_n !== 7'b1111111) begin
        n_bad++;
        $display("FAIL blank[%0d]: an_n=%b seg_n=%b required %b/1111111", i, an_n, seg_n, exp_an);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] codes [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b100, 3'b101, 3'b111};
    for (int i = 0; i < 400; i++) begin
      if (i % 7 == 0) out_mux_sel = codes[$urandom_range(0, 7)];
      a_val = 8'($urandom);
      b_val = 8'($urandom);
      cin_val = 1'($urandom);
      rslt_val = 9'($urandom);
      tick();
      n_cmp++;
      if (an_n !== exp_an || seg_n !== exp_seg) begin
        n_bad++;
        $display("FAIL random[%0d]: an_n=%b seg_n=%b required %b/%b", i, an_n, seg_n, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_mid_reset();
    int guard;
    out_mux_sel = 3'b000;
    guard = 0;
    while (m_pos / SD != 2 && guard < 64) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (guard >= 64) begin
      n_bad++;
      $display("FAIL mid_reset_wait: waited %0d cycles, required under 64", guard);
    end
    reset_n = 1'b0;
    tick();
    n_cmp++;
    if (an_n !== 4'b1111 || seg_n !== 7'b1111111) begin
      n_bad++;
      $display("FAIL mid_reset_edge: an_n=%b seg_n=%b required 1111/1111111", an_n, seg_n);
    end
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if (an_n !== 4'b1110 || seg_n !== 7'b1111111) begin
      n_bad++;
      $display("FAIL mid_reset_restart: an_n=%b seg_n=%b required 1110/1111111", an_n, seg_n);
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      n_cmp++;
      if (an_n !== exp_an || seg_n !== exp_seg) begin
        n_bad++;
        $display("FAIL mid_reset_after[%0d]: an_n=%b seg_n=%b required %b/%b", i, an_n, seg_n, exp_an, exp_seg);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_mode_a();
    test_rslt();
    test_b_and_cin();
    test_err_blink();
    test_blank_codes();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
